// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline-control state encoding and register-address width.
package cpu_pkg;
  localparam int NB_REG = 5;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the sources in ID.
import cpu_pkg::*;
module hazard_detect #(
  parameter int NB_REG = cpu_pkg::NB_REG
) (
  input  logic [NB_REG-1:0] i_id_rs1,
  input  logic [NB_REG-1:0] i_id_rs2,
  input  logic [NB_REG-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  input  logic              i_id_halt,
  output logic              o_ld_use
);
  // x0 never carries a hazard; a HALT in ID reads no registers
  assign o_ld_use = i_ex_mem_read & (i_ex_rd != '0) &
                    ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2)) & ~i_id_halt;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/step/stop/halt sequencing, hazard stalls/flushes and cycle counting.
import cpu_pkg::*;
module pipeline_ctrl #(
  parameter int NB_REG       = cpu_pkg::NB_REG,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_stop,
  input  logic              i_clear,
  input  logic              i_id_halt,
  input  logic [NB_REG-1:0] i_id_rs1,
  input  logic [NB_REG-1:0] i_id_rs2,
  input  logic [NB_REG-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_branch_taken,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_pipe_en,
  output logic              o_halted,
  output logic              o_step_done,
  output logic [NB_CNT-1:0] o_cycle_cnt
);
  localparam int NB_DRN = $clog2(DRAIN_CYCLES) + 1;
  state_t state, state_nx;
  logic [NB_DRN-1:0] drn_cnt;
  logic ld_use, br, hlt, adv;
  hazard_detect #(.NB_REG(NB_REG)) u_hazard (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_mem_read (i_ex_mem_read),
    .i_id_halt     (i_id_halt),
    .o_ld_use      (ld_use)
  );
  always_comb begin
    br            = i_ex_branch_taken;
    hlt           = i_id_halt & ~br;
    adv           = ((state == RUN) & ~i_stop) | (state == STEP);
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_pipe_en     = adv | (state == DRAIN);
    if (adv) begin
      o_pc_en       = br | (~hlt & ~ld_use);
      o_if_id_en    = ~br & ~hlt & ~ld_use;
      o_if_id_flush = br | hlt;
      o_id_ex_flush = br | (~hlt & ld_use);
    end
    // the drain keeps fetching bubbles so only the older instructions retire
    if (state == DRAIN) o_if_id_flush = 1'b1;
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_start ? RUN : i_step ? STEP : IDLE;
      RUN:     state_nx = i_stop ? IDLE : hlt ? DRAIN : RUN;
      STEP:    state_nx = hlt ? DRAIN : IDLE;
      DRAIN:   state_nx = (drn_cnt == '0) ? HALTED : DRAIN;
      HALTED:  state_nx = i_clear ? IDLE : HALTED;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      drn_cnt     <= '0;
      o_halted    <= 1'b0;
      o_step_done <= 1'b0;
      o_cycle_cnt <= '0;
    end else begin
      state       <= state_nx;
      drn_cnt     <= (state != DRAIN && state_nx == DRAIN) ? NB_DRN'(DRAIN_CYCLES - 1) :
                     (state == DRAIN && drn_cnt != '0) ? drn_cnt - 1'b1 : drn_cnt;
      o_halted    <= state_nx == HALTED;
      o_step_done <= state == STEP;
      o_cycle_cnt <= (i_clear & (state == IDLE | state == HALTED)) ? '0 :
                     (o_pipe_en & ~&o_cycle_cnt) ? o_cycle_cnt + 1'b1 : o_cycle_cnt;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random stimulus against a behavioural run-control model.
module tb_pipeline_ctrl;
  localparam int DC = 3;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 0, step = 0, stop = 0, clear = 0, halt = 0, mem_rd = 0, taken = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic pc_en, if_en, if_fl, ex_fl, pipe_en, halted, done;
  logic [31:0] cnt;
  logic pc_en4, if_en4, if_fl4, ex_fl4, pipe_en4, halted4, done4;
  logic [3:0] cnt4;
  int md, left, errors = 0, checks = 0;
  logic m_done, e_pp;
  longint m_cnt;

  pipeline_ctrl #(.NB_CNT(32), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step(step), .i_stop(stop), .i_clear(clear),
    .i_id_halt(halt), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_ex_rd(rd), .i_ex_mem_read(mem_rd),
    .i_ex_branch_taken(taken), .o_pc_en(pc_en), .o_if_id_en(if_en), .o_if_id_flush(if_fl),
    .o_id_ex_flush(ex_fl), .o_pipe_en(pipe_en), .o_halted(halted), .o_step_done(done),
    .o_cycle_cnt(cnt));
  pipeline_ctrl #(.NB_CNT(4), .DRAIN_CYCLES(DC)) dut4 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step(step), .i_stop(stop), .i_clear(clear),
    .i_id_halt(halt), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_ex_rd(rd), .i_ex_mem_read(mem_rd),
    .i_ex_branch_taken(taken), .o_pc_en(pc_en4), .o_if_id_en(if_en4), .o_if_id_flush(if_fl4),
    .o_id_ex_flush(ex_fl4), .o_pipe_en(pipe_en4), .o_halted(halted4), .o_step_done(done4),
    .o_cycle_cnt(cnt4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    md = 0; left = 0; m_done = 0; m_cnt = 0;
  endtask

  // md: 0 idle, 1 run, 2 step, 3 drain, 4 halted
  task automatic check_all();
    logic adv, br, hlt, ld;
    adv = (md == 1 && !stop) || md == 2;
    br  = taken;
    hlt = halt && !br;
    ld  = mem_rd && rd != 0 && (rd == rs1 || rd == rs2) && !halt;
    e_pp = adv || md == 3;
    chk("pipe_en", pipe_en, e_pp);
    chk("pc_en", pc_en, adv && (br || (!hlt && !ld)));
    chk("if_id_en", if_en, adv && !br && !hlt && !ld);
    chk("if_id_flush", if_fl, md == 3 || (adv && (br || hlt)));
    chk("id_ex_flush", ex_fl, adv && (br || (!hlt && ld)));
    chk("halted", halted, md == 4);
    chk("step_done", done, m_done);
    chk("cycle_cnt", cnt, m_cnt > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_cnt);
    chk("cycle_cnt4", cnt4, m_cnt > 15 ? 15 : m_cnt);
  endtask

  task automatic update();
    logic hlt;
    hlt = halt && !taken;
    if (e_pp) m_cnt++;
    if (clear && (md == 0 || md == 4)) m_cnt = 0;
    m_done = md == 2;
    case (md)
      0: md = start ? 1 : step ? 2 : 0;
      1: if (stop) md = 0; else if (hlt) begin md = 3; left = DC; end
      2: if (hlt) begin md = 3; left = DC; end else md = 0;
      3: begin left--; if (left == 0) md = 4; end
      4: if (clear) md = 0;
      default: md = 0;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic quiet();
    start = 0; step = 0; stop = 0; clear = 0; halt = 0; mem_rd = 0; taken = 0;
    rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic async_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
    #1;
    check_all();
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    #2 rst_n = 0;
    model_reset();
    #10 check_all();
    @(negedge clk) rst_n = 1;
    #1;
    @(posedge clk);
    #1;
    tick();
    start = 1; tick(); start = 0;
    repeat (10) tick();
    chk("cnt_after_10", cnt, 10);
    repeat (10) tick();
    chk("cnt4_saturated", cnt4, 15);
    mem_rd = 1; rd = 5; rs2 = 5; tick();
    rd = 0; tick();
    quiet();
    taken = 1; halt = 1; mem_rd = 1; rd = 5; rs1 = 5; tick();
    quiet(); tick();
    stop = 1; tick(); stop = 0; tick();
    start = 1; tick(); start = 0; tick();
    halt = 1; tick(); halt = 0;
    stop = 1; tick(); stop = 0;
    repeat (2) tick();
    chk("halted_entry", halted, 1);
    start = 1; step = 1; tick(); quiet();
    clear = 1; tick(); clear = 0;
    chk("cnt_cleared", cnt, 0);
    tick();
    repeat (3) begin
      step = 1; tick(); step = 0; tick(); tick();
    end
    chk("cnt_after_steps", cnt, 3);
    step = 1; tick(); step = 0;
    halt = 1; tick(); halt = 0;
    tick();
    async_reset();
    chk("cnt_after_reset", cnt, 0);
    step = 1; tick(); step = 0;
    async_reset();
    tick();
    for (int i = 0; i < 600; i++) begin
      start  = $urandom_range(0, 15) == 0;
      step   = $urandom_range(0, 7) == 0;
      stop   = $urandom_range(0, 19) == 0;
      clear  = $urandom_range(0, 3) == 0;
      halt   = $urandom_range(0, 15) == 0;
      mem_rd = $urandom_range(0, 1) == 0;
      taken  = $urandom_range(0, 9) == 0;
      rd     = 5'($urandom_range(0, 3));
      rs1    = 5'($urandom_range(0, 3));
      rs2    = 5'($urandom_range(0, 3));
      tick();
    end
    quiet();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
